// File: rtl/fft_result_capture_if.sv
// Bus port bundle for fft_result_capture: data-bus access from the RS5 core's
// address decoder.
//   en_i    one-cycle access select
//   we_i    byte write enables (nonzero = write)
//   addr_i  local byte address
//   data_i  write data
//   data_o  registered read data
interface fft_result_capture_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  en_i;
  logic [3:0]            we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           data_i;
  logic [31:0]           data_o;

  modport master (output en_i, we_i, addr_i, data_i, input data_o);
  modport slave  (input en_i, we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/fft_result_capture.sv
// FFT result capture peripheral. Arms the FFT accelerator, stores one frame of
// complex results into an internal buffer and exposes control, status and the
// buffer to the core on the data bus. Raises a level interrupt per frame.
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   bus          data-bus slave port (see fft_result_capture_if)
//   out_valid_i  FFT output sample valid
//   dout_r_i     FFT real output (two's complement)
//   dout_i_i     FFT imaginary output (two's complement)
//   accel_en_o   FFT enable, high while capturing
//   irq_o        frame-done interrupt to the PLIC
//   iack_i       interrupt acknowledge
//
// state     | meaning
// S_IDLE    | waiting for START, no capture
// S_CAPTURE | FFT enabled, samples written to buffer
// S_DONE    | full frame captured, waiting for START
module fft_result_capture #(
  parameter int N_POINTS   = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fft_result_capture_if.slave  bus,
  input  logic                 out_valid_i,
  input  logic [OUT_WIDTH-1:0] dout_r_i,
  input  logic [OUT_WIDTH-1:0] dout_i_i,
  output logic                 accel_en_o,
  output logic                 irq_o,
  input  logic                 iack_i
);

  localparam int IDX_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_POINTS - 1);
  // result window starts at byte 0x100, i.e. word 0x40
  localparam logic [WA_W-1:0]  RES_BASE  = WA_W'(64);
  localparam logic [WA_W-1:0]  RES_WORDS = WA_W'(N_POINTS);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] count;
  logic done, overrun, irq_en, irq;
  logic frame_start;

  logic [WA_W-1:0] wa, res_off;
  logic wr_en, rd_en, ctrl_wr, start, clear, cap_wr, last_wr, res_hit;
  logic [IDX_W-1:0] rd_idx;
  logic [2*OUT_WIDTH-1:0] rd_word;
  logic [31:0] status, rdata;
  logic [2*OUT_WIDTH-1:0] mem [N_POINTS];
  logic unused_bits;

  assign wa      = bus.addr_i[ADDR_WIDTH-1:2];
  assign wr_en   = bus.en_i && (bus.we_i != 4'b0);
  assign rd_en   = bus.en_i && (bus.we_i == 4'b0);
  assign ctrl_wr = wr_en && bus.we_i[0] && (wa == '0);
  assign start   = ctrl_wr && bus.data_i[0];
  assign clear   = ctrl_wr && bus.data_i[2];
  assign cap_wr  = (state == S_CAPTURE) && out_valid_i;
  assign last_wr = cap_wr && (count == LAST_IDX);

  assign unused_bits = ^{bus.addr_i[1:0], bus.data_i[31:3]};

  // CLEAR overrides START when both arrive in one write
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nxt   = S_CAPTURE;
            frame_start = 1'b1;
          end
        end
        S_CAPTURE: if (last_wr) state_nxt = S_DONE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      irq_en  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (clear || frame_start) count <= '0;
      else if (cap_wr)          count <= count + 1'b1;

      if (clear || frame_start) done <= 1'b0;
      else if (last_wr)         done <= 1'b1;

      // samples arriving outside CAPTURE are dropped
      if (clear)                                       overrun <= 1'b0;
      else if (out_valid_i && (state != S_CAPTURE))   overrun <= 1'b1;

      if (ctrl_wr) irq_en <= bus.data_i[1];

      // a new frame-done set takes priority over a concurrent acknowledge
      if (clear)                   irq <= 1'b0;
      else if (last_wr && irq_en)  irq <= 1'b1;
      else if (iack_i)             irq <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_wr) mem[count[IDX_W-1:0]] <= {dout_i_i, dout_r_i};
  end

  assign res_off = wa - RES_BASE;
  assign res_hit = (wa >= RES_BASE) && (res_off < RES_WORDS);
  assign rd_idx  = res_off[IDX_W-1:0];
  assign rd_word = mem[rd_idx];
  assign status  = {16'(N_POINTS), 8'(count), 5'b0, overrun, done, state == S_CAPTURE};

  always_comb begin
    rdata = '0;
    if (wa == WA_W'(0))      rdata = {31'b0, irq_en};
    else if (wa == WA_W'(1)) rdata = status;
    else if (res_hit)
      rdata = {16'($signed(rd_word[2*OUT_WIDTH-1:OUT_WIDTH])),
               16'($signed(rd_word[OUT_WIDTH-1:0]))};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   bus.data_o <= '0;
    else if (rd_en) bus.data_o <= rdata;
  end

  assign accel_en_o = (state == S_CAPTURE);
  assign irq_o      = irq;

endmodule

// File: tb/tb_fft_result_capture.sv
// Directed bench for fft_result_capture (N_POINTS=64, OUT_WIDTH=16).
module tb_fft_result_capture;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        out_valid;
  logic [15:0] dout_r, dout_i;
  logic        accel_en, irq, iack;
  logic [31:0] rd;
  int          n_vec = 0;
  int          n_err = 0;

  fft_result_capture_if #(.ADDR_WIDTH(12)) bus ();

  fft_result_capture #(.N_POINTS(64), .OUT_WIDTH(16), .ADDR_WIDTH(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .out_valid_i (out_valid),
    .dout_r_i    (dout_r),
    .dout_i_i    (dout_i),
    .accel_en_o  (accel_en),
    .irq_o       (irq),
    .iack_i      (iack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // all tasks start and end 1 ns after a rising edge
  task automatic bus_write(input logic [11:0] addr, input logic [31:0] data);
    bus.en_i = 1'b1; bus.we_i = 4'hF; bus.addr_i = addr; bus.data_i = data;
    @(posedge clk); #1;
    bus.en_i = 1'b0; bus.we_i = 4'h0;
  endtask

  task automatic bus_read(input logic [11:0] addr, output logic [31:0] data);
    bus.en_i = 1'b1; bus.we_i = 4'h0; bus.addr_i = addr;
    @(posedge clk); #1;
    bus.en_i = 1'b0;
    data = bus.data_o;
  endtask

  task automatic send(input int n, input int k0, input int r_add, input bit neg_i);
    for (int k = k0; k < k0 + n; k++) begin
      out_valid = 1'b1;
      dout_r = 16'(r_add + k);
      dout_i = neg_i ? 16'(-k) : 16'(k);
      @(posedge clk); #1;
    end
    out_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; out_valid = 1'b0; dout_r = '0; dout_i = '0; iack = 1'b0;
    bus.en_i = 1'b0; bus.we_i = '0; bus.addr_i = '0; bus.data_i = '0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset state
    check("rst_data_o", bus.data_o, 32'h0);
    check("rst_accel", {31'b0, accel_en}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    bus_read(12'h004, rd); check("rst_status", rd, 32'h0040_0000);

    // 2: full frame with IRQ_EN
    bus_write(12'h000, 32'h3);
    check("accel_rise", {31'b0, accel_en}, 32'h1);
    send(63, 0, 0, 1'b1);
    check("accel_before_last", {31'b0, accel_en}, 32'h1);
    send(1, 63, 0, 1'b1);
    check("accel_fall", {31'b0, accel_en}, 32'h0);
    check("irq_set", {31'b0, irq}, 32'h1);
    bus_read(12'h004, rd); check("status_done", rd, 32'h0040_4002);
    bus_read(12'h104, rd); check("res1", rd, 32'hFFFF_0001);
    bus_read(12'h1FC, rd); check("res63", rd, 32'hFFC1_003F);
    bus_read(12'h100, rd); check("res0", rd, 32'h0000_0000);
    bus_read(12'h000, rd); check("ctrl_rd", rd, 32'h1);
    bus_read(12'h008, rd); check("unmapped_008", rd, 32'h0);
    bus_read(12'h200, rd); check("unmapped_200", rd, 32'h0);

    // 3: acknowledge and overrun in DONE
    iack = 1'b1; @(posedge clk); #1; iack = 1'b0;
    check("iack_clr", {31'b0, irq}, 32'h0);
    out_valid = 1'b1; dout_r = 16'h1234; dout_i = 16'h5678;
    @(posedge clk); #1; out_valid = 1'b0;
    bus_read(12'h004, rd); check("status_overrun", rd, 32'h0040_4006);
    bus_read(12'h104, rd); check("res1_kept", rd, 32'hFFFF_0001);

    // 4: START ignored in CAPTURE, then CLEAR
    bus_write(12'h000, 32'h3);
    send(10, 0, 100, 1'b0);
    bus_read(12'h004, rd); check("status_cnt10", rd, 32'h0040_0A05);
    bus_read(12'h104, rd); check("res1_new", rd, 32'h0001_0065);
    bus_read(12'h110, rd); check("res4_new", rd, 32'h0004_0068);
    bus_read(12'h12C, rd); check("res11_old", rd, 32'hFFF5_000B);
    bus_write(12'h000, 32'h3);
    send(5, 10, 100, 1'b0);
    bus_read(12'h004, rd); check("start_ignored", rd, 32'h0040_0F05);
    bus_write(12'h000, 32'h6);
    check("clear_accel", {31'b0, accel_en}, 32'h0);
    bus_read(12'h004, rd); check("status_clear", rd, 32'h0040_0000);
    bus_read(12'h000, rd); check("irq_en_kept", rd, 32'h1);

    // 5: START+CLEAR in IDLE
    bus_write(12'h000, 32'h5);
    check("sc_accel", {31'b0, accel_en}, 32'h0);
    bus_read(12'h004, rd); check("sc_status", rd, 32'h0040_0000);

    // frame without IRQ_EN, then enabling does not raise irq
    bus_write(12'h000, 32'h1);
    send(64, 0, 16, 1'b1);
    check("noirq_frame", {31'b0, irq}, 32'h0);
    bus_read(12'h004, rd); check("noirq_status", rd, 32'h0040_4002);
    bus_write(12'h000, 32'h2);
    @(posedge clk); #1;
    check("no_retro_irq", {31'b0, irq}, 32'h0);

    // restart from DONE, iack coincident with set
    bus_write(12'h000, 32'h3);
    send(63, 0, 0, 1'b1);
    iack = 1'b1;
    send(1, 63, 0, 1'b1);
    iack = 1'b0;
    check("set_beats_iack", {31'b0, irq}, 32'h1);

    // START in DONE together with a valid sample
    out_valid = 1'b1; dout_r = 16'h7777; dout_i = 16'h7777;
    bus_write(12'h000, 32'h3);
    out_valid = 1'b0;
    bus_read(12'h004, rd); check("start_valid_status", rd, 32'h0040_0005);

    // 6: async reset mid-capture
    send(30, 0, 16'h200, 1'b0);
    bus_read(12'h100, rd); check("res0_after_drop", rd, 32'h0000_0200);
    bus_read(12'h004, rd); check("status_cnt30", rd, 32'h0040_1E05);
    check("irq_before_rst", {31'b0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_accel", {31'b0, accel_en}, 32'h0);
    check("async_irq", {31'b0, irq}, 32'h0);
    check("async_data_o", bus.data_o, 32'h0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read(12'h004, rd); check("post_rst_status", rd, 32'h0040_0000);
    bus_read(12'h000, rd); check("post_rst_ctrl", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
